multicycle_controller: RTL and testbench

- Moore FSM that sequences the shared-datapath (multi-cycle) RV32I core subset: lw, sw, addi-class, R-type, beq/bne/blt/bge, lui, jal, jalr.
- Drives the single memory port, IR/PC write enables, ALU operand muxes, ALU operation, immediate format and register-file write for the multi-cycle datapath.
- Supports a variable-latency memory through a ready handshake.
- Stops in a sticky halt state on any unsupported encoding.

---
 rtl/multicycle_controller.sv | 222 ++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// multicycle_controller
// Moore control FSM for a shared-datapath (multi-cycle) RV32I subset:
// lw, sw, addi-class, R-type, beq/bne/blt/bge, lui, jal, jalr.
// Memory accesses in FETCH/MEMREAD/MEMWRITE wait on memReady when
// MEM_HANDSHAKE=1. Unsupported encodings park the FSM in a sticky HALT.
// Build option: define INSTR_COUNT_EN to add the retired-instruction
// counter output instrCount (CNT_W bits, wraps).
module multicycle_controller #(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic             zero,
  input  logic             resSign,
  input  logic             memReady,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ALUControl,
  output logic [2:0]       ImmSrc,
  output logic             RegWrite,
  output logic             illegal
`ifdef INSTR_COUNT_EN
  ,
  output logic [CNT_W-1:0] instrCount
`endif
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXEC_R, S_EXEC_I, S_ALUWB, S_BRANCH, S_LUI, S_JAL, S_JALR, S_HALT
  } state_t;

  state_t     state, state_next;
  logic       ready;
  logic [2:0] alu_op;
  logic       alu_legal;
  logic       taken;
  logic       pc_write_raw, ir_write_raw, mem_write_raw, reg_write_raw;

  assign ready = MEM_HANDSHAKE ? memReady : 1'b1;

  // Architectural write enables are held off while reset is asserted, so a
  // reset mid-instruction cannot commit anything.
  assign PCWrite  = pc_write_raw  & rst;
  assign IRWrite  = ir_write_raw  & rst;
  assign MemWrite = mem_write_raw & rst;
  assign RegWrite = reg_write_raw & rst;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_FETCH;
    else      state <= state_next;
  end

  // ALU operation and legality for the EXEC states, decoded from funct3/funct7.
  always_comb begin
    alu_op    = ALU_ADD;
    alu_legal = 1'b1;
    case (funct3)
      3'b000:  alu_op = (state == S_EXEC_R && funct7 == 7'b0100000) ? ALU_SUB : ALU_ADD;
      3'b111:  alu_op = ALU_AND;
      3'b110:  alu_op = ALU_OR;
      3'b100:  alu_op = ALU_XOR;
      3'b010:  alu_op = ALU_SLT;
      default: alu_legal = 1'b0;
    endcase
    if (state == S_EXEC_R && funct7 != 7'b0000000 && funct7 != 7'b0100000)
      alu_legal = 1'b0;
  end

  // Branch condition from the SUB result flags; unknown funct3 never branches.
  always_comb begin
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = !zero;
      3'b100:  taken = resSign;
      3'b101:  taken = !resSign;
      default: taken = 1'b0;
    endcase
  end

  // Next-state and Moore outputs.
  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next    = state;
    pc_write_raw  = 1'b0;
    ir_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    AdrSrc        = 1'b0;
    ResultSrc     = 2'b00;
    ALUSrcA       = 2'b00;
    ALUSrcB       = 2'b00;
    ALUControl    = ALU_ADD;
    ImmSrc        = IMM_I;
    illegal       = 1'b0;
    case (state)
      S_FETCH: begin
        ALUSrcB      = 2'b10;
        ResultSrc    = 2'b10;
        pc_write_raw = ready;
        ir_write_raw = ready;
        if (ready) state_next = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LOAD:   state_next = S_MEMADR;
          OP_STORE:  begin ImmSrc = IMM_S; state_next = S_MEMADR; end
          OP_R:      state_next = S_EXEC_R;
          OP_I:      state_next = S_EXEC_I;
          OP_BRANCH: begin ImmSrc = IMM_B; state_next = S_BRANCH; end
          OP_LUI:    begin ImmSrc = IMM_U; state_next = S_LUI; end
          OP_JAL:    begin ImmSrc = IMM_J; state_next = S_JAL; end
          OP_JALR:   state_next = S_JALR;
          default:   state_next = S_HALT;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ImmSrc     = (op == OP_STORE) ? IMM_S : IMM_I;
        state_next = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc     = 2'b01;
        reg_write_raw = 1'b1;
        state_next    = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc        = 1'b1;
        mem_write_raw = 1'b1;
        if (ready) state_next = S_FETCH;
      end
      S_EXEC_R, S_EXEC_I: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = (state == S_EXEC_I) ? 2'b01 : 2'b00;
        ALUControl = alu_op;
        state_next = alu_legal ? S_ALUWB : S_HALT;
      end
      S_ALUWB: begin
        reg_write_raw = 1'b1;
        state_next    = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA      = 2'b10;
        ALUControl   = ALU_SUB;
        pc_write_raw = taken;
        state_next   = S_FETCH;
      end
      S_JALR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        state_next = S_JAL;
      end
      S_JAL: begin
        pc_write_raw = 1'b1;
        ALUSrcA      = 2'b01;
        ALUSrcB      = 2'b10;
        state_next   = S_ALUWB;
      end
      S_LUI: begin
        ImmSrc        = IMM_U;
        ResultSrc     = 2'b11;
        reg_write_raw = 1'b1;
        state_next    = S_FETCH;
      end
      S_HALT:  illegal = 1'b1;
      default: state_next = S_HALT;
    endcase
  end

`ifdef INSTR_COUNT_EN
  // Retired-instruction counter: one count per return to FETCH from elsewhere.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      instrCount <= '0;
    else if (state != S_FETCH && state_next == S_FETCH)
      instrCount <= instrCount + CNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller
// Expands each instruction into its expected per-cycle control vectors
// (a queue of steps) and compares the DUT against the queue head every cycle.
`timescale 1ns/1ps
module tb_multicycle_controller;

  localparam int CNT_W = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       zero, resSign, memReady;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ALUControl, ImmSrc;
`ifdef INSTR_COUNT_EN
  logic [CNT_W-1:0] instrCount;
  logic       c2_pcw, c2_adr, c2_mw, c2_irw, c2_rw, c2_ill;
  logic [1:0] c2_rs, c2_a, c2_b;
  logic [2:0] c2_alu, c2_imm;
  logic [1:0] c2_cnt;
`endif

  multicycle_controller #(.MEM_HANDSHAKE(1'b1), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7(funct7),
    .zero(zero), .resSign(resSign), .memReady(memReady),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegWrite(RegWrite),
    .illegal(illegal)
`ifdef INSTR_COUNT_EN
    , .instrCount(instrCount)
`endif
  );

`ifdef INSTR_COUNT_EN
  multicycle_controller #(.MEM_HANDSHAKE(1'b1), .CNT_W(2)) dut_c2 (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7(funct7),
    .zero(zero), .resSign(resSign), .memReady(memReady),
    .PCWrite(c2_pcw), .AdrSrc(c2_adr), .MemWrite(c2_mw), .IRWrite(c2_irw),
    .ResultSrc(c2_rs), .ALUSrcA(c2_a), .ALUSrcB(c2_b),
    .ALUControl(c2_alu), .ImmSrc(c2_imm), .RegWrite(c2_rw),
    .illegal(c2_ill), .instrCount(c2_cnt)
  );
`endif

  always #5 clk = ~clk;

  // One expected cycle of an instruction.
  typedef struct {
    logic       pcw, adr, mw, rw, ill;
    logic [1:0] rs, a, b;
    logic [2:0] alu, imm;
    bit         fetch;   // PCWrite = IRWrite = memReady
    bit         branch;  // PCWrite = branch condition
    bit         wait_mem;// repeats while memReady = 0
    bit         mem;     // data-memory access (directed stalls apply)
    bit         halt;    // repeats forever
  } step_t;

  step_t       q[$];
  int unsigned model_cnt = 0;
  int          halt_cycles = 0;
  int          n_checks = 0, n_fail = 0;

  logic [6:0]  nx_op;
  logic [2:0]  nx_f3;
  logic [6:0]  nx_f7;
  bit          directed;
  int          stalls_left;
  logic        dir_zero, dir_sign;
  int          t_cyc, t_mw, t_rw, t_pcw, t_adr, last_rw;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t op=%b f3=%b f7=%b)",
               name, act, exp, $time, op, funct3, funct7);
    end
  endtask

  function automatic step_t blank();
    step_t s;
    s = '{default: 0};
    return s;
  endfunction

  function automatic logic [2:0] imm_of(input logic [6:0] o);
    case (o)
      7'b0100011: return 3'b001;
      7'b1100011: return 3'b010;
      7'b1101111: return 3'b011;
      7'b0110111: return 3'b100;
      default:    return 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] alu_of(input bit r, input logic [2:0] f3, input logic [6:0] f7);
    case (f3)
      3'b000:  return (r && f7 == 7'b0100000) ? 3'b001 : 3'b000;
      3'b111:  return 3'b010;
      3'b110:  return 3'b011;
      3'b100:  return 3'b100;
      3'b010:  return 3'b101;
      default: return 3'b000;
    endcase
  endfunction

  function automatic bit exec_legal(input bit r, input logic [2:0] f3, input logic [6:0] f7);
    return (f3 inside {3'b000, 3'b111, 3'b110, 3'b100, 3'b010}) &&
           (!r || f7 == 7'b0000000 || f7 == 7'b0100000);
  endfunction

  function automatic logic br_taken(input logic [2:0] f3, input logic z, input logic n);
    case (f3)
      3'b000:  return z;
      3'b001:  return !z;
      3'b100:  return n;
      3'b101:  return !n;
      default: return 1'b0;
    endcase
  endfunction

  // Expand one instruction into its cycle-by-cycle control expectations.
  function automatic void build(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7);
    step_t s, wb, hlt, jal;
    bit r;
    q.delete();
    halt_cycles = 0;
    wb  = blank(); wb.rw = 1'b1;
    hlt = blank(); hlt.ill = 1'b1; hlt.halt = 1;
    jal = blank(); jal.pcw = 1'b1; jal.a = 2'b01; jal.b = 2'b10;
    s = blank(); s.b = 2'b10; s.rs = 2'b10; s.fetch = 1; s.wait_mem = 1; q.push_back(s);
    s = blank(); s.a = 2'b01; s.b = 2'b01; s.imm = imm_of(o); q.push_back(s);
    case (o)
      7'b0000011, 7'b0100011: begin
        s = blank(); s.a = 2'b10; s.b = 2'b01;
        s.imm = (o == 7'b0100011) ? 3'b001 : 3'b000; q.push_back(s);
        s = blank(); s.adr = 1'b1; s.wait_mem = 1; s.mem = 1;
        s.mw = (o == 7'b0100011); q.push_back(s);
        if (o == 7'b0000011) begin
          s = blank(); s.rs = 2'b01; s.rw = 1'b1; q.push_back(s);
        end
      end
      7'b0110011, 7'b0010011: begin
        r = (o == 7'b0110011);
        s = blank(); s.a = 2'b10; s.b = r ? 2'b00 : 2'b01; s.alu = alu_of(r, f3, f7);
        q.push_back(s);
        q.push_back(exec_legal(r, f3, f7) ? wb : hlt);
      end
      7'b1100011: begin
        s = blank(); s.a = 2'b10; s.alu = 3'b001; s.branch = 1; q.push_back(s);
      end
      7'b0110111: begin
        s = blank(); s.imm = 3'b100; s.rs = 2'b11; s.rw = 1'b1; q.push_back(s);
      end
      7'b1101111: begin q.push_back(jal); q.push_back(wb); end
      7'b1100111: begin
        s = blank(); s.a = 2'b10; s.b = 2'b01; q.push_back(s);
        q.push_back(jal); q.push_back(wb);
      end
      default: q.push_back(hlt);
    endcase
  endfunction

  task automatic compare(input step_t s);
    logic exp_pcw, exp_irw;
    exp_irw = s.fetch ? memReady : 1'b0;
    exp_pcw = s.fetch ? memReady : (s.branch ? br_taken(funct3, zero, resSign) : s.pcw);
    check("PCWrite",    PCWrite,    exp_pcw);
    check("IRWrite",    IRWrite,    exp_irw);
    check("AdrSrc",     AdrSrc,     s.adr);
    check("MemWrite",   MemWrite,   s.mw);
    check("RegWrite",   RegWrite,   s.rw);
    check("ResultSrc",  ResultSrc,  s.rs);
    check("ALUSrcA",    ALUSrcA,    s.a);
    check("ALUSrcB",    ALUSrcB,    s.b);
    check("ALUControl", ALUControl, s.alu);
    check("ImmSrc",     ImmSrc,     s.imm);
    check("illegal",    illegal,    s.ill);
`ifdef INSTR_COUNT_EN
    check("instrCount",     instrCount, model_cnt);
    check("instrCount_w2",  c2_cnt,     model_cnt % 4);
`endif
  endtask

  task automatic advance(input step_t s);
    if (s.halt) halt_cycles++;
    else if (s.wait_mem && !memReady) ;
    else begin
      void'(q.pop_front());
      if (q.size() == 0) model_cnt++;
    end
  endtask

  // One clock: drive inputs after the edge, compare on the falling edge.
  task automatic cycle();
    step_t s;
    @(posedge clk); #1;
    if (q.size() == 0) begin
      op = nx_op; funct3 = nx_f3; funct7 = nx_f7;
      build(nx_op, nx_f3, nx_f7);
    end
    s = q[0];
    if (directed) begin
      memReady = 1'b1;
      if (s.mem && stalls_left > 0) begin memReady = 1'b0; stalls_left--; end
      zero = dir_zero; resSign = dir_sign;
    end else begin
      memReady = ($urandom_range(0, 3) != 0);
      zero     = 1'($urandom_range(0, 1));
      resSign  = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    compare(s);
    t_cyc++;
    t_mw  += int'(MemWrite);
    t_rw  += int'(RegWrite);
    t_adr += int'(AdrSrc);
    if (RegWrite) last_rw = t_cyc;
    if (PCWrite && !s.fetch) t_pcw++;
    advance(s);
  endtask

  task automatic finish_instr();
    int n = 0;
    while (q.size() != 0 && !q[0].halt) begin
      if (n >= 200) begin check("instr_completes", 32'd0, 32'd1); break; end
      cycle();
      n++;
    end
  endtask

  task automatic run_one(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                         input int stalls, input logic z, input logic sg);
    nx_op = o; nx_f3 = f3; nx_f7 = f7;
    stalls_left = stalls; dir_zero = z; dir_sign = sg;
    t_cyc = 0; t_mw = 0; t_rw = 0; t_pcw = 0; t_adr = 0; last_rw = 0;
    cycle();
    finish_instr();
  endtask

  // Asynchronous reset pulse landing mid-cycle.
  task automatic do_reset();
    @(posedge clk); #3;
    memReady = 1'b1;
    rst = 1'b0;
    #1;
    check("rst_PCWrite",  PCWrite,  1'b0);
    check("rst_IRWrite",  IRWrite,  1'b0);
    check("rst_MemWrite", MemWrite, 1'b0);
    check("rst_RegWrite", RegWrite, 1'b0);
    check("rst_illegal",  illegal,  1'b0);
    check("rst_ResultSrc_fetch", ResultSrc, 2'b10);
    check("rst_ALUSrcB_fetch",   ALUSrcB,   2'b10);
    check("rst_AdrSrc_fetch",    AdrSrc,    1'b0);
`ifdef INSTR_COUNT_EN
    check("rst_instrCount", instrCount, 0);
`endif
    @(negedge clk);
    memReady = 1'b0;
    #1 rst = 1'b1;
    q.delete();
    model_cnt = 0;
  endtask

  task automatic pick_random();
    logic [2:0] legal3 [5] = '{3'b000, 3'b111, 3'b110, 3'b100, 3'b010};
    int k = $urandom_range(0, 9);
    case (k)
      0:       nx_op = 7'b0000011;
      1:       nx_op = 7'b0100011;
      2, 3:    nx_op = 7'b0110011;
      4, 5:    nx_op = 7'b0010011;
      6:       nx_op = 7'b1100011;
      7:       nx_op = 7'b0110111;
      8:       nx_op = ($urandom_range(0, 1) != 0) ? 7'b1101111 : 7'b1100111;
      default: nx_op = 7'($urandom());
    endcase
    if ((nx_op == 7'b0110011 || nx_op == 7'b0010011) && $urandom_range(0, 9) != 0)
      nx_f3 = legal3[$urandom_range(0, 4)];
    else
      nx_f3 = 3'($urandom());
    case ($urandom_range(0, 19))
      0, 1:    nx_f7 = 7'($urandom());
      default: nx_f7 = ($urandom_range(0, 1) != 0) ? 7'b0000000 : 7'b0100000;
    endcase
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; memReady = 1'b0; zero = 1'b0; resSign = 1'b0;
    op = '0; funct3 = '0; funct7 = '0;
    directed = 1;
    repeat (2) @(posedge clk);
    do_reset();

    // add x3,x1,x2: 4 cycles, single RegWrite in the last one
    run_one(7'b0110011, 3'b000, 7'b0000000, 0, 1'b0, 1'b0);
    check("add_cycles", t_cyc, 4);
    check("add_regwrites", t_rw, 1);
    check("add_regwrite_cycle", last_rw, 4);

    // sw with 3 stall cycles in MEMWRITE
    run_one(7'b0100011, 3'b010, 7'b0000000, 3, 1'b0, 1'b0);
    check("sw_cycles", t_cyc, 7);
    check("sw_memwrite_cycles", t_mw, 4);
    check("sw_adrsrc_cycles", t_adr, 4);
    check("sw_regwrites", t_rw, 0);

    // beq taken then not taken
    run_one(7'b1100011, 3'b000, 7'b0000000, 0, 1'b1, 1'b0);
    check("beq_taken_cycles", t_cyc, 3);
    check("beq_taken_pcwrite", t_pcw, 1);
    run_one(7'b1100011, 3'b000, 7'b0000000, 0, 1'b0, 1'b0);
    check("beq_not_taken_pcwrite", t_pcw, 0);

    // jalr: 5 cycles, one jump PCWrite, one RegWrite
    run_one(7'b1100111, 3'b000, 7'b0000000, 0, 1'b0, 1'b0);
    check("jalr_cycles", t_cyc, 5);
    check("jalr_pcwrite", t_pcw, 1);
    check("jalr_regwrites", t_rw, 1);

    // lw with 2 read stalls, lui
    run_one(7'b0000011, 3'b010, 7'b0000000, 2, 1'b0, 1'b0);
    check("lw_cycles", t_cyc, 7);
    check("lw_regwrites", t_rw, 1);
    run_one(7'b0110111, 3'b000, 7'b0000000, 0, 1'b0, 1'b0);
    check("lui_cycles", t_cyc, 3);

    // unsupported opcode: sticky halt, then reset mid-cycle
    run_one(7'b1111111, 3'b000, 7'b0000000, 0, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      cycle();
      check("halt_illegal_held", illegal, 1'b1);
    end
    do_reset();

`ifdef INSTR_COUNT_EN
    // lui, addi, lw after reset -> 3 retired
    run_one(7'b0110111, 3'b000, 7'b0000000, 0, 1'b0, 1'b0);
    run_one(7'b0010011, 3'b000, 7'b0000000, 0, 1'b0, 1'b0);
    run_one(7'b0000011, 3'b010, 7'b0000000, 0, 1'b0, 1'b0);
    nx_op = 7'b0110011; nx_f3 = 3'b000; nx_f7 = 7'b0000000;
    cycle();
    check("count_after_3", instrCount, 3);
    finish_instr();
    run_one(7'b0100011, 3'b010, 7'b0000000, 0, 1'b0, 1'b0);
    nx_op = 7'b0110111; nx_f3 = 3'b000; nx_f7 = 7'b0000000;
    cycle();
    check("count_w2_after_5", c2_cnt, 1);
    finish_instr();
`endif

    // randomized traffic with stalls, halts and occasional mid-instruction resets
    directed = 0;
    for (int i = 0; i < 3000; i++) begin
      if (q.size() == 0) pick_random();
      else if (q[0].halt && halt_cycles >= 12) do_reset();
      else if ($urandom_range(0, 99) == 0) do_reset();
      if (q.size() == 0) pick_random();
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
